mem_pool_read_arbiter: RTL and testbench
========================================

# mem_pool_read_arbiter

Arbitrates read requests from the conv, datasaver and misc engines onto the per-bank read ports of one memory-pool bank group, and returns each bank's read data to the requester that issued it. Sits directly upstream of the bank group: drives its per-bank read-enable/address vectors, consumes its read-data vector (fixed 2-cycle RAM read latency), and presents registered, per-requester responses.

## Interface
- BANK_NUM, 4, number of banks in the group
- BANK_ADDR_WIDTH, 12, per-bank address width
- BANK_DATA_WIDTH, 64, per-bank data width (unit width × unit count)
- REQ_NUM, 3, number of requesters (0 conv, 1 datasaver, 2 misc)
- RAM_LATENCY, 2, bank read latency in cycles; must match the bank group
- BANK_SEL_W (derived), max(1, clog2(BANK_NUM))

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous, active-low reset
- req_valid_i  in  REQ_NUM  request valid per requester
- req_ready_o  out  REQ_NUM  request accepted this cycle (combinational)
- req_bank_i  in  REQ_NUM*BANK_SEL_W  target bank per requester
- req_addr_i  in  REQ_NUM*BANK_ADDR_WIDTH  word address per requester
- read_bank_en_o  out  BANK_NUM  to bank group read enables (registered)
- read_addr_o  out  BANK_NUM*BANK_ADDR_WIDTH  to bank group read addresses (registered)
- read_data_i  in  BANK_NUM*BANK_DATA_WIDTH  from bank group read data
- rsp_valid_o  out  REQ_NUM  response valid, one pulse per accepted request
- rsp_data_o  out  REQ_NUM*BANK_DATA_WIDTH  response data per requester

## Operation
- Handshake: request transfers when req_valid_i[r] & req_ready_o[r]. Valid must be held with bank/addr stable until ready; ready may depend combinationally on valid.
- Per-bank round-robin arbitration: for bank b, candidates are requesters with valid and req_bank == b. Search starts at rr_ptr[b]; first candidate wins. After a grant on b, rr_ptr[b] ← (winner+1) mod REQ_NUM; pointer unchanged if no grant.
- Each requester targets one bank per cycle, so up to min(BANK_NUM, REQ_NUM) grants per cycle; losers see ready=0 and retry.
- Out-of-range bank (req_bank ≥ BANK_NUM): ready=1 immediately, no RAM read, response still generated with data all-zero.
- Grant stage registers read_bank_en_o[b]=1, read_addr_o slice b = winner's addr; read_bank_en_o[b]=0 and address holds its last value when ungranted.
- Tag pipeline: per requester, a RAM_LATENCY+1 deep shift register of {valid, bank, oob}. At tail, rsp_data_o slice r ← read_data_i slice bank (or 0 if oob), rsp_valid_o[r] ← 1, both registered.
- No response backpressure: requesters must sink every rsp_valid pulse. rsp_data_o holds last value when rsp_valid_o=0.
- Per-requester responses return in issue order (fixed latency).

## Timing
- Request accepted at edge t → read_bank_en_o high in cycle t+1 → bank data at t+3 → rsp_valid_o high in cycle t+4. Latency = RAM_LATENCY+2 = 4, fixed, including oob requests.
- Throughput: one request per requester per cycle when banks do not conflict.
- Reset (rst_n low, async): read_bank_en_o=0, read_addr_o=0, rsp_valid_o=0, rsp_data_o=0, all tags cleared, rr_ptr=0. req_ready_o is 0 while rst_n is low.
- Reset mid-operation drops all in-flight requests; no response pulses for them after release. First accept is possible in the first cycle with rst_n high.

## Structure
- Shared package mem_pool_pkg: REQ_CONV=0, REQ_SAVER=1, REQ_MISC=2, MEM_POOL_RAM_LATENCY=2, clog2-based bank-select width function.
- Sub-module rr_arbiter (REQ_NUM-wide request in, one-hot grant out, internal pointer), instantiated once per bank in a generate loop. Tag pipeline and response mux stay in the top module.

## Test plan
- Single read: conv requests bank 2, addr 0x05A, RAM preloaded with 0x1122334455667788 → read_bank_en_o=4'b0100 with addr 0x05A at t+1; rsp_valid_o[0] at t+4 with that data; other rsp_valid stay 0.
- Parallel no-conflict: conv→bank0, saver→bank1, misc→bank3 same cycle → all ready=1, read_bank_en_o=4'b1011, three responses in the same cycle at t+4.
- Conflict round-robin: all three hold valid on bank1 for 6 cycles from reset → grants in order 0,1,2,0,1,2; each requester gets exactly 2 responses, each 4 cycles after its grant.
- Out-of-range bank: BANK_NUM=3, misc requests bank 3 → ready=1, no read_bank_en_o bit set, rsp_valid_o[2] at t+4 with data 0.
- Back-to-back streaming: saver issues addrs 0..15 on bank0 consecutively, no contention → 16 consecutive rsp_valid_o[1] pulses starting t+4, data in address order.
- Reset mid-flight: accept 3 requests, assert rst_n low for 1 cycle at t+2 → all outputs 0 immediately, no response pulses afterward, next request after release responds 4 cycles after its accept.

Source files
------------

// File: rtl/mem_pool_pkg.sv
// Shared memory-pool constants: requester ids, RAM latency and select-width helper.
package mem_pool_pkg;
  localparam int REQ_CONV             = 0;
  localparam int REQ_SAVER            = 1;
  localparam int REQ_MISC             = 2;
  localparam int MEM_POOL_RAM_LATENCY = 2;

  // Index width for n items, never narrower than one bit.
  function automatic int bank_sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the internal pointer.
module rr_arbiter
  import mem_pool_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  localparam int PW = bank_sel_w(N);

  logic [PW-1:0] ptr, ptr_nxt;

  // Walk offsets high to low so the candidate closest to ptr overwrites the rest.
  always_comb begin : sel
    int idx;
    gnt     = '0;
    ptr_nxt = ptr;
    idx     = 0;
    for (int i = N-1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        ptr_nxt  = PW'((idx + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= ptr_nxt;
  end
endmodule

// File: rtl/mem_pool_read_arbiter.sv
// Per-bank round-robin read arbiter for one memory-pool bank group, with a
// fixed-latency tag pipeline that routes bank read data back to each requester.
module mem_pool_read_arbiter
  import mem_pool_pkg::*;
#(
  parameter  int BANK_NUM        = 4,
  parameter  int BANK_ADDR_WIDTH = 12,
  parameter  int BANK_DATA_WIDTH = 64,
  parameter  int REQ_NUM         = 3,
  parameter  int RAM_LATENCY     = MEM_POOL_RAM_LATENCY,
  localparam int BANK_SEL_W      = bank_sel_w(BANK_NUM)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [REQ_NUM-1:0]                   req_valid_i,
  output logic [REQ_NUM-1:0]                   req_ready_o,
  input  logic [REQ_NUM*BANK_SEL_W-1:0]        req_bank_i,
  input  logic [REQ_NUM*BANK_ADDR_WIDTH-1:0]   req_addr_i,
  output logic [BANK_NUM-1:0]                  read_bank_en_o,
  output logic [BANK_NUM*BANK_ADDR_WIDTH-1:0]  read_addr_o,
  input  logic [BANK_NUM*BANK_DATA_WIDTH-1:0]  read_data_i,
  output logic [REQ_NUM-1:0]                   rsp_valid_o,
  output logic [REQ_NUM*BANK_DATA_WIDTH-1:0]   rsp_data_o
);
  localparam int RL = RAM_LATENCY;

  logic [REQ_NUM-1:0]                       vld, oob, hit;
  logic [REQ_NUM-1:0][BANK_SEL_W-1:0]       bank;
  logic [REQ_NUM-1:0][BANK_ADDR_WIDTH-1:0]  addr;
  logic [BANK_NUM-1:0][REQ_NUM-1:0]         cand, gnt;
  logic [BANK_NUM-1:0][BANK_ADDR_WIDTH-1:0] win_addr, rd_addr;
  logic [BANK_NUM-1:0][BANK_DATA_WIDTH-1:0] rdata;
  logic [REQ_NUM-1:0][BANK_DATA_WIDTH-1:0]  rsp_data;

  logic [REQ_NUM-1:0][RL:0]                 vld_pipe, oob_pipe;
  logic [REQ_NUM-1:0][RL:0][BANK_SEL_W-1:0] bank_pipe;

  // Nothing is accepted while reset is held.
  assign vld   = req_valid_i & {REQ_NUM{rst_n}};
  assign bank  = req_bank_i;
  assign addr  = req_addr_i;
  assign rdata = read_data_i;

  for (genvar r = 0; r < REQ_NUM; r++) begin : g_oob
    assign oob[r] = int'(bank[r]) >= BANK_NUM;
  end

  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    for (genvar r = 0; r < REQ_NUM; r++) begin : g_cand
      assign cand[b][r] = vld[r] & (int'(bank[r]) == b);
    end
    rr_arbiter #(.N(REQ_NUM)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (cand[b]),
      .gnt   (gnt[b])
    );
  end

  always_comb begin
    hit      = '0;
    win_addr = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      hit |= gnt[b];
      for (int r = 0; r < REQ_NUM; r++)
        if (gnt[b][r]) win_addr[b] |= addr[r];
    end
  end

  // Out-of-range requests are accepted at once and answered with zero data.
  assign req_ready_o = vld & (hit | oob);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_bank_en_o <= '0;
      rd_addr        <= '0;
    end else begin
      for (int b = 0; b < BANK_NUM; b++) begin
        read_bank_en_o[b] <= |gnt[b];
        if (|gnt[b]) rd_addr[b] <= win_addr[b];
      end
    end
  end

  assign read_addr_o = rd_addr;

  // Tag stage k is live in cycle accept+1+k; the tail lines up with bank data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      oob_pipe  <= '0;
      bank_pipe <= '0;
    end else begin
      for (int r = 0; r < REQ_NUM; r++) begin
        vld_pipe[r]  <= {vld_pipe[r][RL-1:0],  req_ready_o[r]};
        oob_pipe[r]  <= {oob_pipe[r][RL-1:0],  oob[r]};
        bank_pipe[r] <= {bank_pipe[r][RL-1:0], bank[r]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_o <= '0;
      rsp_data    <= '0;
    end else begin
      for (int r = 0; r < REQ_NUM; r++) begin
        rsp_valid_o[r] <= vld_pipe[r][RL];
        if (vld_pipe[r][RL])
          rsp_data[r] <= oob_pipe[r][RL] ? '0 : rdata[bank_pipe[r][RL]];
      end
    end
  end

  assign rsp_data_o = rsp_data;
endmodule

// File: tb/tb_mem_pool_read_arbiter.sv
// Directed bench: two arbiter instances (4 banks, 3 banks) behind a 2-cycle RAM model.
module tb_mem_pool_read_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // 4-bank instance
  logic [2:0]       valid_a, ready_a, rspv_a;
  logic [2:0][1:0]  bank_a;
  logic [2:0][11:0] addr_a;
  logic [3:0]       en_a;
  logic [3:0][11:0] raddr_a;
  logic [3:0][63:0] rd1_a, rd2_a;
  logic [2:0][63:0] rspd_a;

  // 3-bank instance: bank select 3 is out of range
  logic [2:0]       valid_b, ready_b, rspv_b;
  logic [2:0][1:0]  bank_b;
  logic [2:0][11:0] addr_b;
  logic [2:0]       en_b;
  logic [2:0][11:0] raddr_b;
  logic [2:0][63:0] rd1_b, rd2_b;
  logic [2:0][63:0] rspd_b;

  mem_pool_read_arbiter u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(valid_a), .req_ready_o(ready_a),
    .req_bank_i(bank_a), .req_addr_i(addr_a),
    .read_bank_en_o(en_a), .read_addr_o(raddr_a), .read_data_i(rd2_a),
    .rsp_valid_o(rspv_a), .rsp_data_o(rspd_a)
  );

  mem_pool_read_arbiter #(.BANK_NUM(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(valid_b), .req_ready_o(ready_b),
    .req_bank_i(bank_b), .req_addr_i(addr_b),
    .read_bank_en_o(en_b), .read_addr_o(raddr_b), .read_data_i(rd2_b),
    .rsp_valid_o(rspv_b), .rsp_data_o(rspd_b)
  );

  function automatic logic [63:0] f(input int b, input logic [11:0] a);
    if (b == 2 && a == 12'h05A) return 64'h1122334455667788;
    return {16'hC0DE, 8'(b), 28'h0, a};
  endfunction

  // Bank group model: data appears two cycles after the enable cycle.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (en_a[b]) rd1_a[b] <= f(b, raddr_a[b]);
    for (int b = 0; b < 3; b++)
      if (en_b[b]) rd1_b[b] <= f(b, raddr_b[b]);
    rd2_a <= rd1_a;
    rd2_b <= rd1_b;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [2:0] exp_g [6];
    int cnt [3];
    int w;
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    rd1_a = '0; rd2_a = '0; rd1_b = '0; rd2_b = '0;
    valid_a = '0; bank_a = '0; addr_a = '0;
    valid_b = '0; bank_b = '0; addr_b = '0;
    rst_n = 1'b0;

    // reset state, ready gated low
    #1 valid_a = 3'b111;
    #1;
    chk("rst_ready", ready_a, 0);
    chk("rst_en", en_a, 0);
    chk("rst_addr", raddr_a, 0);
    chk("rst_rspv", rspv_a, 0);
    for (int r = 0; r < 3; r++) chk($sformatf("rst_rspd%0d", r), rspd_a[r], 0);
    valid_a = '0;
    tick(); tick();
    rst_n = 1'b1;

    // single read
    bank_a[0] = 2'd2; addr_a[0] = 12'h05A; valid_a = 3'b001;
    #1 chk("single_ready", ready_a, 3'b001);
    tick(); valid_a = '0;
    chk("single_en", en_a, 4'b0100);
    chk("single_addr", raddr_a[2], 12'h05A);
    tick(); tick();
    chk("single_rspv_t3", rspv_a, 0);
    tick();
    chk("single_rspv_t4", rspv_a, 3'b001);
    chk("single_data", rspd_a[0], 64'h1122334455667788);
    tick();
    chk("single_rspv_t5", rspv_a, 0);
    chk("single_hold", rspd_a[0], 64'h1122334455667788);

    // parallel, no conflict
    bank_a = '{2'd3, 2'd1, 2'd0}; addr_a = '{12'h030, 12'h020, 12'h010}; valid_a = 3'b111;
    #1 chk("par_ready", ready_a, 3'b111);
    tick(); valid_a = '0;
    chk("par_en", en_a, 4'b1011);
    tick(); tick();
    chk("par_rspv_t3", rspv_a, 0);
    tick();
    chk("par_rspv_t4", rspv_a, 3'b111);
    chk("par_data0", rspd_a[0], f(0, 12'h010));
    chk("par_data1", rspd_a[1], f(1, 12'h020));
    chk("par_data2", rspd_a[2], f(3, 12'h030));

    // conflict round robin from a fresh reset
    rst_n = 1'b0; #1 rst_n = 1'b1;
    tick();
    bank_a = '{2'd1, 2'd1, 2'd1}; addr_a = '{12'h102, 12'h101, 12'h100};
    cnt = '{0, 0, 0};
    for (int c = 0; c <= 10; c++) begin
      valid_a = (c < 6) ? 3'b111 : 3'b000;
      #1;
      if (c < 6) chk($sformatf("rr_ready_c%0d", c), ready_a, exp_g[c]);
      if (c >= 1) begin
        chk($sformatf("rr_en_c%0d", c), en_a, (c - 1 < 6) ? 4'b0010 : 4'b0000);
        if (c - 1 < 6) chk($sformatf("rr_addr_c%0d", c), raddr_a[1], 12'h100 + (c - 1) % 3);
      end
      if (c >= 4 && c - 4 < 6) begin
        w = (c - 4) % 3;
        chk($sformatf("rr_rspv_c%0d", c), rspv_a, exp_g[c - 4]);
        chk($sformatf("rr_data_c%0d", c), rspd_a[w], f(1, 12'(12'h100 + w)));
      end else begin
        chk($sformatf("rr_rspv_c%0d", c), rspv_a, 0);
      end
      for (int r = 0; r < 3; r++) cnt[r] += int'(rspv_a[r]);
      tick();
    end
    for (int r = 0; r < 3; r++) chk($sformatf("rr_count%0d", r), 64'(cnt[r]), 2);

    // out-of-range bank on the 3-bank instance, preceded by a real read
    bank_b[2] = 2'd2; addr_b[2] = 12'h05A; valid_b = 3'b100;
    #1 chk("oob_pre_ready", ready_b, 3'b100);
    tick();
    chk("oob_pre_en", en_b, 3'b100);
    bank_b[2] = 2'd3; addr_b[2] = 12'h001;
    #1 chk("oob_ready", ready_b, 3'b100);
    tick(); valid_b = '0;
    chk("oob_en", en_b, 3'b000);
    tick();
    chk("oob_pre_rspv_t3", rspv_b, 0);
    tick();
    chk("oob_pre_rspv", rspv_b, 3'b100);
    chk("oob_pre_data", rspd_b[2], 64'h1122334455667788);
    tick();
    chk("oob_rspv", rspv_b, 3'b100);
    chk("oob_data", rspd_b[2], 0);
    tick();
    chk("oob_rspv_after", rspv_b, 0);

    // back-to-back streaming on bank 0
    bank_a = '0;
    for (int c = 0; c <= 20; c++) begin
      valid_a = (c < 16) ? 3'b010 : 3'b000;
      addr_a[1] = 12'(c);
      #1;
      if (c < 16) chk($sformatf("str_ready_c%0d", c), ready_a, 3'b010);
      if (c >= 4 && c < 20) begin
        chk($sformatf("str_rspv_c%0d", c), rspv_a, 3'b010);
        chk($sformatf("str_data_c%0d", c), rspd_a[1], f(0, 12'(c - 4)));
      end else begin
        chk($sformatf("str_rspv_c%0d", c), rspv_a, 0);
      end
      tick();
    end

    // reset while three reads are in flight
    bank_a = '{2'd2, 2'd1, 2'd0}; addr_a = '{12'h003, 12'h002, 12'h001}; valid_a = 3'b111;
    #1 chk("mid_ready", ready_a, 3'b111);
    tick(); valid_a = '0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", en_a, 0);
    chk("mid_rst_addr", raddr_a, 0);
    chk("mid_rst_rspv", rspv_a, 0);
    for (int r = 0; r < 3; r++) chk($sformatf("mid_rst_rspd%0d", r), rspd_a[r], 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1 chk($sformatf("mid_quiet_k%0d", k), rspv_a, 0);
      tick();
    end
    bank_a[0] = 2'd0; addr_a[0] = 12'h007; valid_a = 3'b001;
    #1 chk("post_ready", ready_a, 3'b001);
    tick(); valid_a = '0;
    chk("post_en", en_a, 4'b0001);
    tick(); tick();
    chk("post_rspv_t3", rspv_a, 0);
    tick();
    chk("post_rspv_t4", rspv_a, 3'b001);
    chk("post_data", rspd_a[0], f(0, 12'h007));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
